// File: rtl/button_reset_gen.sv
`default_nettype none
// ============================================================================
//  Module   : button_reset_gen
//  Brief    : Synchronises and debounces the two active-low board buttons,
//             produces debounced levels and press pulses, and sequences a
//             minimum-length Z80 reset after global reset and on button 0.
//  Revision : 1.0  - initial release
// ============================================================================
module button_reset_gen #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int RESET_CYCLES    = 64
) (
    input  logic       CLK50MHZ,
    input  logic       RESET,
    input  logic [1:0] BUTTON_N,
    output logic [1:0] BUTTON,
    output logic [1:0] BUTTON_PRESS,
    output logic       Z80_RESET_N,
    output logic       SYS_RESET
);

    localparam int               DB_W       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int               RST_W      = $clog2(RESET_CYCLES);
    localparam logic [DB_W-1:0]  C_DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DB_W-1:0]  C_DB_ONE   = DB_W'(1);
    localparam logic [RST_W-1:0] C_RST_LAST = RST_W'(RESET_CYCLES - 1);
    localparam logic [RST_W-1:0] C_RST_ONE  = RST_W'(1);

    typedef enum logic [1:0] {
        ST_ASSERT = 2'b00,
        ST_HOLD   = 2'b01,
        ST_RUN    = 2'b10
    } state_t;

    logic [1:0] sync1_q;
    logic [1:0] sync2_q;
    logic [1:0] stable_vec;
    logic [1:0] press_vec;

    // Two-flop synchroniser for both raw buttons; idles at "released"
    always_ff @(posedge CLK50MHZ) begin
        if (RESET) begin
            sync1_q <= 2'b11;
            sync2_q <= 2'b11;
        end else begin
            sync1_q <= BUTTON_N;
            sync2_q <= sync1_q;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_debounce
            logic [DB_W-1:0] cnt_q;
            logic [DB_W-1:0] cnt_d;
            logic            stable_q;
            logic            stable_d;
            logic            press_q;
            logic            press_d;

            // Accept a new level only after it has differed from the stable
            // level on DEBOUNCE_CYCLES consecutive edges; any return clears it
            always_comb begin
                cnt_d    = cnt_q;
                stable_d = stable_q;
                press_d  = 1'b0;
                if (sync2_q[gi] == stable_q) begin
                    cnt_d = '0;
                end else if (cnt_q == C_DB_LAST) begin
                    cnt_d    = '0;
                    stable_d = sync2_q[gi];
                    // Active-low input: a new stable 0 is a press
                    press_d  = ~sync2_q[gi];
                end else begin
                    cnt_d = cnt_q + C_DB_ONE;
                end
            end

            // Debounce state register
            always_ff @(posedge CLK50MHZ) begin
                if (RESET) begin
                    cnt_q    <= '0;
                    stable_q <= 1'b1;
                    press_q  <= 1'b0;
                end else begin
                    cnt_q    <= cnt_d;
                    stable_q <= stable_d;
                    press_q  <= press_d;
                end
            end

            assign stable_vec[gi] = stable_q;
            assign press_vec[gi]  = press_q;
        end
    endgenerate

    assign BUTTON       = ~stable_vec;
    assign BUTTON_PRESS = press_vec;

    state_t             state_q;
    state_t             state_d;
    logic [RST_W-1:0]   rcnt_q;
    logic [RST_W-1:0]   rcnt_d;
    logic               z80_rst_n_q;
    logic               sys_rst_q;

    // Reset sequencer next-state: fixed ASSERT tail, HOLD while button 0 is
    // down, RUN until the next debounced press of button 0
    always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q;
        case (state_q)
            ST_ASSERT: begin
                if (rcnt_q == C_RST_LAST) begin
                    rcnt_d  = '0;
                    state_d = BUTTON[0] ? ST_HOLD : ST_RUN;
                end else begin
                    rcnt_d = rcnt_q + C_RST_ONE;
                end
            end
            ST_HOLD: begin
                if (!BUTTON[0]) begin
                    state_d = ST_ASSERT;
                    rcnt_d  = '0;
                end
            end
            ST_RUN: begin
                if (BUTTON_PRESS[0]) begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d = ST_ASSERT;
                rcnt_d  = '0;
            end
        endcase
    end

    // Sequencer state and reset outputs, registered from the next state so
    // both outputs change together on the same edge
    always_ff @(posedge CLK50MHZ) begin
        if (RESET) begin
            state_q     <= ST_ASSERT;
            rcnt_q      <= '0;
            z80_rst_n_q <= 1'b0;
            sys_rst_q   <= 1'b1;
        end else begin
            state_q     <= state_d;
            rcnt_q      <= rcnt_d;
            z80_rst_n_q <= (state_d == ST_RUN);
            sys_rst_q   <= (state_d != ST_RUN);
        end
    end

    assign Z80_RESET_N = z80_rst_n_q;
    assign SYS_RESET   = sys_rst_q;

endmodule
`default_nettype wire

// File: tb/tb_button_reset_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_button_reset_gen
//  Brief    : Self-checking bench for button_reset_gen with a timestamp-based
//             reference model, directed scenarios and random button traffic.
//  Revision : 1.0  - initial release
// ============================================================================
module tb_button_reset_gen;

    localparam int D = 4;
    localparam int R = 8;

    logic       clk          = 1'b0;
    logic       RESET        = 1'b1;
    logic [1:0] BUTTON_N     = 2'b11;
    logic [1:0] BUTTON;
    logic [1:0] BUTTON_PRESS;
    logic       Z80_RESET_N;
    logic       SYS_RESET;

    int vectors = 0;
    int errors  = 0;

    // Reference model state: raw sample history per button, accepted level,
    // and the edge index at which the current reset tail started
    bit         hist [2][D+2];
    bit         stable_m [2];
    bit   [1:0] exp_btn   = 2'b00;
    bit   [1:0] exp_press = 2'b00;
    bit         running   = 1'b0;
    bit         holding   = 1'b0;
    int         edge_n    = 0;
    int         start_n   = 0;

    button_reset_gen #(
        .DEBOUNCE_CYCLES (D),
        .RESET_CYCLES    (R)
    ) dut (
        .CLK50MHZ     (clk),
        .RESET        (RESET),
        .BUTTON_N     (BUTTON_N),
        .BUTTON       (BUTTON),
        .BUTTON_PRESS (BUTTON_PRESS),
        .Z80_RESET_N  (Z80_RESET_N),
        .SYS_RESET    (SYS_RESET)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock edge of the reference model. A level is accepted when the
    // raw samples 2..D+1 edges old all disagree with the accepted level.
    // Z80 reset rises R edges after the tail start unless button 0 is down.
    task automatic model_edge(input logic r, input logic [1:0] bn);
        bit old_b0;
        bit old_p0;
        bit differ;
        edge_n++;
        old_b0 = exp_btn[0];
        old_p0 = exp_press[0];
        if (r) begin
            running = 1'b0;
            holding = 1'b0;
            start_n = edge_n;
        end else if (running) begin
            if (old_p0) begin
                running = 1'b0;
                holding = 1'b1;
            end
        end else if (holding) begin
            if (!old_b0) begin
                holding = 1'b0;
                start_n = edge_n;
            end
        end else if (edge_n - start_n == R) begin
            if (old_b0) holding = 1'b1;
            else        running = 1'b1;
        end
        for (int i = 0; i < 2; i++) begin
            exp_press[i] = 1'b0;
            if (r) begin
                for (int k = 0; k < D + 2; k++) hist[i][k] = 1'b1;
                stable_m[i] = 1'b1;
            end else begin
                for (int k = 0; k < D + 1; k++) hist[i][k] = hist[i][k+1];
                hist[i][D+1] = bn[i];
                differ = 1'b1;
                for (int k = 0; k < D; k++)
                    if (hist[i][k] == stable_m[i]) differ = 1'b0;
                if (differ) begin
                    stable_m[i]  = ~stable_m[i];
                    exp_press[i] = ~stable_m[i];
                end
            end
            exp_btn[i] = ~stable_m[i];
        end
    endtask

    task automatic step(input logic r, input logic [1:0] bn);
        RESET    = r;
        BUTTON_N = bn;
        @(posedge clk);
        model_edge(r, bn);
        #1;
        check("button",      int'(BUTTON),       int'(exp_btn));
        check("press",       int'(BUTTON_PRESS), int'(exp_press));
        check("z80_reset_n", int'(Z80_RESET_N),  int'(running));
        check("sys_reset",   int'(SYS_RESET),    int'(!running));
    endtask

    initial begin
        int   first_hi;
        int   first_lo;
        int   seen;
        int   pulses;
        int   pulse_at;
        int   rise_at;
        int   fall_at;
        int   rem [2];
        logic rr;
        logic [1:0] lvl;

        // Global reset, then the release tail with both buttons up
        for (int c = 0; c < 5; c++) step(1'b1, 2'b11);
        check("rst_button", int'(BUTTON), 0);
        check("rst_press",  int'(BUTTON_PRESS), 0);
        check("rst_z80",    int'(Z80_RESET_N), 0);
        check("rst_sys",    int'(SYS_RESET), 1);
        first_hi = 0;
        seen     = 0;
        for (int c = 1; c <= 20; c++) begin
            step(1'b0, 2'b11);
            if (Z80_RESET_N && first_hi == 0) first_hi = c;
            if (BUTTON != 2'b00) seen = 1;
        end
        check("rst_release_edge", first_hi, R);
        check("rst_button_quiet", seen, 0);

        // Glitch of D-1 cycles on button 0 must be ignored
        seen = 0;
        for (int c = 0; c < 3; c++) step(1'b0, 2'b10);
        for (int c = 0; c < 10; c++) begin
            step(1'b0, 2'b11);
            if (BUTTON != 2'b00 || BUTTON_PRESS != 2'b00 || !Z80_RESET_N) seen = 1;
        end
        check("glitch_ignored", seen, 0);

        // Clean press of button 0 held 20 cycles
        rise_at = 0; fall_at = 0; pulses = 0;
        for (int c = 1; c <= 20; c++) begin
            step(1'b0, 2'b10);
            if (BUTTON[0] && rise_at == 0) rise_at = c;
            if (!Z80_RESET_N && fall_at == 0) fall_at = c;
            pulses += int'(BUTTON_PRESS[0]);
        end
        check("press_button_edge", rise_at, D + 2);
        check("press_z80_fall",    fall_at, D + 3);
        check("press_pulses",      pulses, 1);

        // Release: debounced fall, then RESET_CYCLES+1 tail
        first_lo = 0; first_hi = 0; pulses = 0;
        for (int c = 1; c <= 25; c++) begin
            step(1'b0, 2'b11);
            if (!BUTTON[0] && first_lo == 0) first_lo = c;
            if (Z80_RESET_N && first_hi == 0) first_hi = c;
            pulses += int'(BUTTON_PRESS[0]);
        end
        check("release_button_edge", first_lo, D + 2);
        check("release_z80_rise",    first_hi, D + 2 + R + 1);
        check("release_no_pulse",    pulses, 0);

        // Bounce on button 1, then held low
        pulses = 0; seen = 0; pulse_at = 0;
        for (int c = 0; c < 20; c++) begin
            step(1'b0, {((c / 2) % 2 == 1), 1'b1});
            pulses += int'(BUTTON_PRESS[1]);
            if (!Z80_RESET_N) seen = 1;
        end
        for (int c = 1; c <= 15; c++) begin
            step(1'b0, 2'b01);
            if (BUTTON_PRESS[1]) begin
                pulses++;
                pulse_at = c;
            end
            if (!Z80_RESET_N) seen = 1;
        end
        check("bounce_pulses", pulses, 1);
        check("bounce_edge",   pulse_at, D + 2);
        check("bounce_z80",    seen, 0);
        for (int c = 0; c < 12; c++) step(1'b0, 2'b11);

        // Button 0 held through global reset
        for (int c = 0; c < 3; c++) step(1'b1, 2'b10);
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            step(1'b0, 2'b10);
            if (Z80_RESET_N) seen = 1;
        end
        check("held_stays_reset", seen, 0);
        check("held_button",      int'(BUTTON[0]), 1);
        first_hi = 0;
        for (int c = 1; c <= 25; c++) begin
            step(1'b0, 2'b11);
            if (Z80_RESET_N && first_hi == 0) first_hi = c;
        end
        check("held_release_rise", first_hi, D + 2 + R + 1);

        // Global reset pulsed while the sequencer is in HOLD
        for (int c = 0; c < 10; c++) step(1'b0, 2'b10);
        step(1'b1, 2'b11);
        check("midrst_button", int'(BUTTON), 0);
        check("midrst_press",  int'(BUTTON_PRESS), 0);
        check("midrst_z80",    int'(Z80_RESET_N), 0);
        check("midrst_sys",    int'(SYS_RESET), 1);
        first_hi = 0; pulses = 0;
        for (int c = 1; c <= 20; c++) begin
            step(1'b0, 2'b11);
            if (Z80_RESET_N && first_hi == 0) first_hi = c;
            pulses += int'(BUTTON_PRESS[0]);
        end
        check("midrst_release_edge", first_hi, R);
        check("midrst_no_stale",     pulses, 0);

        // Random button traffic with occasional global resets
        lvl    = 2'b11;
        rem[0] = 0;
        rem[1] = 0;
        for (int c = 0; c < 4000; c++) begin
            rr = ($urandom_range(0, 399) == 0);
            for (int i = 0; i < 2; i++) begin
                if (rem[i] == 0) begin
                    lvl[i] = ~lvl[i];
                    rem[i] = int'($urandom_range(1, 12));
                end else begin
                    rem[i]--;
                end
            end
            step(rr, lvl);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire
